serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract engine that time-multiplexes a single instance of the team's existing `full_adder` cell across WIDTH cycles. It holds the operands in shift registers and a carry flip-flop. A small FSM sequences one bit per clock from LSB to MSB. A start/busy/done handshake lets a host or CPU datapath launch operations. It serves as the area-minimal arithmetic option next to the parallel ripple-carry adders.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width; never below 1 so the counter always exists.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared one bit per clock by the serial engine.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial A+B+C_in / A-B engine: one full_adder reused LSB to MSB over WIDTH clocks.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_res_nxt;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    full_adder u_fa (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign w_c_msb_in = r_carry;
    assign w_res_nxt  = {w_fa_sum, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_accept    = start;
                w_state_nxt = start ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                // Subtract is A + ~B + 1: invert B and force the initial carry.
                r_opa   <= A;
                r_opb   <= SUB ? ~B : B;
                r_carry <= SUB ? 1'b1 : C_in;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_opa   <= r_opa >> 1;
                r_opb   <= r_opb >> 1;
                r_carry <= w_fa_cout;
                r_cnt   <= r_cnt + 1'b1;
                r_res   <= w_res_nxt;
                // Publish only the completed result; outputs stay frozen during RUN.
                if (w_last) begin
                    r_sum  <= w_res_nxt;
                    r_cout <= w_fa_cout;
                    r_ovf  <= w_c_msb_in ^ w_fa_cout;
                end
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign Sum      = r_sum;
    assign C_out    = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: vector table plus protocol sequences.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       SUB;
    logic [7:0] A;
    logic [7:0] B;
    logic       C_in;
    logic       busy;
    logic       done;
    logic [7:0] Sum;
    logic       C_out;
    logic       overflow;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[7];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .SUB      (SUB),
        .A        (A),
        .B        (B),
        .C_in     (C_in),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .C_out    (C_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation and wait for done; idx is the number of cycles after the accepting edge.
    task automatic run_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output int busy_cnt, output int done_idx);
        @(negedge clk);
        SUB = sub; A = a; B = b; C_in = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'hA5; B = 8'h5A; C_in = ~cin; SUB = ~sub;
        busy_cnt = 0;
        done_idx = -1;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                done_idx = i;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int di;
        int d1;
        int d2;
        logic [7:0] s1;
        logic [7:0] s2;

        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; SUB = 1'b0; A = '0; B = '0; C_in = 1'b0;

        vecs[0] = '{"add_ovf",    1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{"add_carry",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"add_cin",    1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{"sub_borrow", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{"sub_ovf",    1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{"add_cin_ovf",1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{"sub_equal",  1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(Sum), 0);
        check("rst_cout", 32'(C_out), 0);
        check("rst_ovf", 32'(overflow), 0);

        // reset held with start: reset wins
        start = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 0);
        start = 1'b0;
        reset = 1'b0;

        foreach (vecs[k]) begin
            run_op(vecs[k].sub, vecs[k].a, vecs[k].b, vecs[k].cin, bc, di);
            check({vecs[k].name, "_busy"}, 32'(bc), 8);
            check({vecs[k].name, "_lat"}, 32'(di), 9);
            check({vecs[k].name, "_sum"}, 32'(Sum), 32'(vecs[k].exp_sum));
            check({vecs[k].name, "_cout"}, 32'(C_out), 32'(vecs[k].exp_cout));
            check({vecs[k].name, "_ovf"}, 32'(overflow), 32'(vecs[k].exp_ovf));
            @(negedge clk);
            check({vecs[k].name, "_done_pulse"}, 32'(done), 0);
            check({vecs[k].name, "_hold"}, 32'(Sum), 32'(vecs[k].exp_sum));
        end

        // start pulsed during RUN is ignored; outputs keep previous result while running
        @(negedge clk);
        SUB = 1'b0; A = 8'h12; B = 8'h34; C_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        SUB = 1'b1; A = 8'hFF; B = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_hold_sum", 32'(Sum), 32'h00);
        check("run_busy", 32'(busy), 1);
        di = -1;
        for (int i = 4; i <= 20; i++) begin
            if (done) begin
                di = i;
                break;
            end
            @(negedge clk);
        end
        check("ignore_lat", 32'(di), 9);
        check("ignore_sum", 32'(Sum), 32'h46);
        @(negedge clk);
        check("ignore_no_restart", 32'(busy), 0);

        // start held high: back-to-back acceptance from DONE
        @(negedge clk);
        SUB = 1'b0; A = 8'h01; B = 8'h02; C_in = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 8'h20; B = 8'h22;
        d1 = -1; d2 = -1; s1 = '0; s2 = '0;
        for (int i = 1; i <= 30; i++) begin
            if (done && d1 < 0) begin
                d1 = i; s1 = Sum;
            end else if (done && d2 < 0) begin
                d2 = i; s2 = Sum;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_first_lat", 32'(d1), 9);
        check("b2b_spacing", 32'(d2 - d1), 9);
        check("b2b_sum1", 32'(s1), 32'h03);
        check("b2b_sum2", 32'(s2), 32'h42);

        // reset at RUN cycle 4 clears everything; next op completes normally
        @(negedge clk);
        @(negedge clk);
        SUB = 1'b0; A = 8'h33; B = 8'h44; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_sum", 32'(Sum), 0);
        check("mid_rst_cout", 32'(C_out), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        run_op(1'b0, 8'h5A, 8'h3C, 1'b0, bc, di);
        check("post_rst_lat", 32'(di), 9);
        check("post_rst_sum", 32'(Sum), 32'h96);
        check("post_rst_ovf", 32'(overflow), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
